// File: rtl/mult_ctrl.sv
// Sequencing controller for a shift-and-add multiplier: drives load/add/shift strobes to an external accumulator.
// Optional sticky busy-start error flag enabled by defining MULT_CTRL_BUSY_ERR_EN.
module mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic m_lsb,
    output logic load,
    output logic sh,
    output logic ad,
    output logic busy,
    output logic done
`ifdef MULT_CTRL_BUSY_ERR_EN
    ,
    output logic err
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TEST,
        S_ADD,
        S_SHIFT,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    // NOTE: outputs are registered alongside the state, each branch setting the
    // values that decode from the state being entered, so they stay glitch-free Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            load  <= 1'b0;
            sh    <= 1'b0;
            ad    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            load <= 1'b0;
            sh   <= 1'b0;
            ad   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        load  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state <= S_TEST;
                    cnt   <= '0;
                end
                S_TEST: begin
                    if (m_lsb) begin
                        state <= S_ADD;
                        ad    <= 1'b1;
                    end else begin
                        state <= S_SHIFT;
                        sh    <= 1'b1;
                    end
                end
                S_ADD: begin
                    state <= S_SHIFT;
                    sh    <= 1'b1;
                end
                S_SHIFT: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_WAIT;
                    end else begin
                        state <= S_TEST;
                    end
                end
                S_WAIT: begin
                    // accumulator's final register needs one more cycle
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MULT_CTRL_BUSY_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (start && state != S_IDLE && state != S_DONE) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: directed and random multipliers against an expected strobe trace
// built from the multiplier bits, with a small accumulator model driving m_lsb.
module tb_mult_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n, start, m_lsb;
    logic load, sh, ad, busy, done;
`ifdef MULT_CTRL_BUSY_ERR_EN
    logic err;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mreg;
    logic         err_exp;

    mult_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .m_lsb (m_lsb),
        .load  (load),
        .sh    (sh),
        .ad    (ad),
        .busy  (busy),
        .done  (done)
`ifdef MULT_CTRL_BUSY_ERR_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // exp_str is {load, sh, ad, done}
    task automatic check_outs(input string tag, input logic [3:0] exp_str, input logic exp_busy);
        check({tag, ".strobes"}, {28'd0, load, sh, ad, done}, {28'd0, exp_str});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
        check({tag, ".onehot"}, 32'($countones({load, sh, ad}) <= 1), 32'd1);
`ifdef MULT_CTRL_BUSY_ERR_EN
        check({tag, ".err"}, {31'd0, err}, {31'd0, err_exp});
`endif
    endtask

    // Runs one multiplication starting from a negedge in an IDLE cycle.
    // hold keeps start high throughout; abort_at >= 0 pulses reset in that trace cycle.
    task automatic do_op(input logic [W-1:0] mult, input bit hold, input int abort_at);
        logic [3:0] exp_q[$];
        exp_q.push_back(4'b1000);
        for (int b = 0; b < W; b++) begin
            exp_q.push_back(4'b0000);
            if (mult[b]) exp_q.push_back(4'b0010);
            exp_q.push_back(4'b0100);
        end
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0001);

        start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_outs($sformatf("op%0h.c%0d", mult, i), exp_q[i], 1'b1);
            if (i == abort_at) begin
                rst_n   = 1'b0;
                start   = 1'b0;
                err_exp = 1'b0;
                #1;
                check_outs("rst_mid", 4'b0000, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check_outs("post_rst", 4'b0000, 1'b0);
                end
                return;
            end
            if (exp_q[i][3]) mreg = mult;
            else if (exp_q[i][2]) mreg = mreg >> 1;
            m_lsb = mreg[0];
            if (hold) start = 1'b1;
            else if (i == exp_q.size() - 1) start = 1'b0;
            else start = 1'($urandom_range(0, 1));
            if (start && !exp_q[i][0]) err_exp = 1'b1;
        end
        @(negedge clk);
        check_outs($sformatf("op%0h.idle", mult), 4'b0000, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        m_lsb   = 1'b0;
        mreg    = '0;
        err_exp = 1'b0;

        repeat (2) @(negedge clk);
        check_outs("reset", 4'b0000, 1'b0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_outs("idle_no_start", 4'b0000, 1'b0);
        end

        do_op(4'b0000, 1'b0, -1);
        do_op(4'b1111, 1'b0, -1);
        do_op(4'b1010, 1'b0, -1);
        do_op(4'b0000, 1'b0, 3);
        do_op(4'b0110, 1'b0, -1);

        do_op(4'b1001, 1'b1, -1);
        do_op(4'b0101, 1'b1, -1);
        do_op(4'b1100, 1'b0, -1);

        for (int n = 0; n < 10; n++) begin
            do_op(W'($urandom), 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of multiplier bits processed (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock (rising edge).
REQ-003 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, the request to begin a multiplication (level, sampled in IDLE only).
REQ-005 The block SHALL have port m_lsb, input, 1 bit, the current multiplier LSB (accumulator bit 0).
REQ-006 The block SHALL have port load, output, 1 bit, the accumulator load strobe.
REQ-007 The block SHALL have port sh, output, 1 bit, the accumulator right-shift strobe.
REQ-008 The block SHALL have port ad, output, 1 bit, the accumulator add strobe.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse when the product is valid on the accumulator final output.
REQ-011 The block SHALL have port err, output, 1 bit, present only with MULT_CTRL_BUSY_ERR_EN (see REQ-027).

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD, TEST, ADD, SHIFT, WAIT and DONE; all outputs SHALL be Moore-decoded from the state register only.
REQ-013 In IDLE, start=1 at a rising edge SHALL go to LOAD; start=0 SHALL stay in IDLE.
REQ-014 In LOAD, load=1; next state SHALL be TEST; bit counter cleared to 0.
REQ-015 In TEST, all strobes SHALL be 0; m_lsb=1 SHALL go to ADD, m_lsb=0 SHALL go to SHIFT; m_lsb SHALL be sampled in TEST only.
REQ-016 In ADD, ad=1; next state SHALL be SHIFT.
REQ-017 In SHIFT, sh=1; the counter SHALL increment; if the counter before increment equals WIDTH-1, the next state SHALL be WAIT, else TEST.
REQ-018 In WAIT, all strobes SHALL be 0 (covers the accumulator's one-cycle final register delay); next state SHALL be DONE.
REQ-019 In DONE, done=1 for exactly one cycle; next state SHALL be IDLE unconditionally, with no back-to-back start from DONE.
REQ-020 At most one of load/sh/ad SHALL be high in any cycle.
REQ-021 Latency from the start-sampling edge to the done cycle SHALL be 3 + 2*WIDTH + (number of 1 bits in multiplier) cycles.
REQ-022 start asserted while busy=1 SHALL be ignored and SHALL NOT restart or extend the operation.
REQ-023 The counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL never wrap within one operation.

Reset
REQ-024 rst_n=0 SHALL force IDLE immediately (asynchronously), regardless of the current state, and clear the counter.
REQ-025 During and after reset, load, sh, ad, busy, done and err SHALL all be 0.
REQ-026 On reset mid-operation, the operation SHALL be abandoned without a done pulse; the first start after rst_n rises SHALL begin a clean operation.

Configuration
REQ-027 With MULT_CTRL_BUSY_ERR_EN defined, err SHALL be a sticky flag set on any edge where start=1 and the state is not IDLE or DONE; err SHALL be cleared only by reset, and it SHALL NOT alter sequencing.
REQ-028 Without MULT_CTRL_BUSY_ERR_EN, the err port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 WIDTH=4, multiplier 0000, start sampled at edge k -> load high in k+1; sh pulses only, with no ad; done high in cycle k+11 only.
REQ-030 WIDTH=4, multiplier 1111 -> 4 ad pulses, each immediately followed by sh; done in cycle k+15; busy high k+1..k+15.
REQ-031 WIDTH=4, multiplier 1010 (LSB first 0,1,0,1) -> strobe sequence load, sh, ad, sh, sh, ad, sh; done in cycle k+13.
REQ-032 rst_n pulsed low during the second TEST -> all outputs 0 at once, no done pulse; a new start then completes normally.
REQ-033 start held high continuously -> operations repeat with exactly one IDLE cycle between done and the next load; with MULT_CTRL_BUSY_ERR_EN, err=1 from the cycle after LOAD, and it remains 1.
REQ-034 Every cycle of all scenarios -> the one-hot check of REQ-020 holds (load+sh+ad <= 1).
